// File: rtl/led_pkg.sv
// Shared types and constants for the LED-string frame path: frame geometry,
// arbiter state encoding and GRB colour words used by the frame producers.
package led_pkg;

  localparam int LED_W            = 24;
  localparam int NUM_LEDS_DEFAULT = 3;
  localparam int FRAME_W_DEFAULT  = LED_W * NUM_LEDS_DEFAULT;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    SEND,
    LATCH
  } arb_state_t;

  // Colour words are GRB ordered, matching the wire order of the string.
  localparam logic [LED_W-1:0] RED    = 24'h00FF00;
  localparam logic [LED_W-1:0] YELLOW = 24'hFFFF00;
  localparam logic [LED_W-1:0] GREEN  = 24'hFF0000;
  localparam logic [LED_W-1:0] OFF    = 24'h000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero; expired_o is high while the
// count is zero. Shared between the latch gap and the refresh interval.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/led_frame_arbiter.sv
// Round-robin arbiter sharing one WS2812 serializer between two frame sources,
// with an enforced latch gap after each frame and periodic re-send of the held frame.
module led_frame_arbiter
  import led_pkg::*;
#(
  parameter int  NUM_LEDS       = NUM_LEDS_DEFAULT,
  parameter int  LATCH_CYCLES   = 6000,
  parameter int  REFRESH_CYCLES = 3_333_333,
  localparam int FRAME_W        = LED_W * NUM_LEDS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  input  logic [FRAME_W-1:0] req0_frame,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [FRAME_W-1:0] req1_frame,
  output logic               req1_ready,
  output logic [FRAME_W-1:0] ser_frame,
  output logic               ser_start,
  input  logic               ser_busy,
  output logic               grant_id,
  output logic               active,
  output logic [15:0]        frame_count
);

  localparam int TIMER_W = $clog2(max_int(LATCH_CYCLES, REFRESH_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] LATCH_LOAD   = TIMER_W'(LATCH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REFRESH_LOAD = TIMER_W'(REFRESH_CYCLES - 1);

  arb_state_t         state_q;
  logic [FRAME_W-1:0] ser_frame_q;
  logic               ser_start_q;
  logic               grant_id_q;
  logic               active_q;
  logic               rr_prefer1_q;
  logic               held_valid_q;
  logic [15:0]        frame_count_q;

  logic               any_valid;
  logic               in_idle;
  logic               grant0;
  logic               grant1;
  logic               refresh_go;
  logic               timer_load;
  logic               timer_en;
  logic               timer_expired;
  logic [TIMER_W-1:0] timer_value;

  assign any_valid = req0_valid | req1_valid;
  assign in_idle   = (state_q == IDLE);

  // Ready is combinational, so it is masked by reset_n to stay low during reset.
  assign grant0 = reset_n & in_idle & req0_valid & (~req1_valid | ~rr_prefer1_q);
  assign grant1 = reset_n & in_idle & req1_valid & (~req0_valid |  rr_prefer1_q);

  assign refresh_go = in_idle & held_valid_q & ~any_valid & timer_expired;

  // Reload for the latch gap on leaving SEND, and for the refresh interval on
  // entering IDLE or whenever a request shows up while idle.
  assign timer_load  = ((state_q == SEND) & ~ser_busy)
                     | ((state_q == LATCH) & timer_expired)
                     | (in_idle & any_valid);
  assign timer_value = (state_q == SEND) ? LATCH_LOAD : REFRESH_LOAD;
  assign timer_en    = (state_q == LATCH) | (in_idle & held_valid_q & ~any_valid);

  cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (timer_load),
    .en_i      (timer_en),
    .value_i   (timer_value),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ser_frame_q   <= '0;
      ser_start_q   <= 1'b0;
      grant_id_q    <= 1'b0;
      active_q      <= 1'b0;
      rr_prefer1_q  <= 1'b0;
      held_valid_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      ser_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            ser_frame_q  <= grant1 ? req1_frame : req0_frame;
            grant_id_q   <= grant1;
            rr_prefer1_q <= grant0;
            held_valid_q <= 1'b1;
          end
          // A refresh re-launches the held frame without touching the pointer.
          if (grant0 || grant1 || refresh_go) begin
            ser_start_q   <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            state_q       <= LOAD;
          end
        end
        LOAD: begin
          active_q <= 1'b1;
          state_q  <= ARM;
        end
        ARM: begin
          state_q <= SEND;
        end
        SEND: begin
          if (!ser_busy) begin
            state_q <= LATCH;
          end
        end
        LATCH: begin
          if (timer_expired) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign ser_frame   = ser_frame_q;
  assign ser_start   = ser_start_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign frame_count = frame_count_q;

endmodule
